// File: rtl/amiga_kbd_pkg.sv
// rtl/amiga_kbd_pkg.sv - shared codes, tags and state encoding for the Amiga keyboard transmitter
package amiga_kbd_pkg;

    localparam logic [7:0] KC_INIT_PWR  = 8'hFD;
    localparam logic [7:0] KC_INIT_END  = 8'hFE;
    localparam logic [7:0] KC_LOST_SYNC = 8'hF9;

    localparam logic [1:0] KMT_KEYBOARD = 2'b10;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SEND,
        ST_WAIT_HS,
        ST_WAIT_REL,
        ST_RESYNC
    } kbd_state_t;

    // Up/down flag travels last on the wire, so rotate it to the LSB.
    function automatic logic [7:0] kbd_encode(input logic [7:0] d);
        return {d[6:0], d[7]};
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// rtl/kbd_fifo.sv - synchronous keycode FIFO with count, full/empty and same-cycle push/pop
module kbd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk_sys) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/amiga_kbd_tx.sv
// rtl/amiga_kbd_tx.sv - keycode stream to Amiga KCLK/KDAT serial protocol with CIA handshake and resync
module amiga_kbd_tx
    import amiga_kbd_pkg::*;
#(
    parameter int PHASE      = 560,
    parameter int HS_MIN     = 28,
    parameter int HS_TIMEOUT = 4004000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       KBD_MOUSE_STROBE,
    input  logic [1:0] KBD_MOUSE_TYPE,
    input  logic [7:0] KBD_MOUSE_DATA,
    input  logic       kdat_in,
    output logic       kclk_out,
    output logic       kdat_out,
    output logic       busy,
    output logic       overflow
);

    localparam int PW = (PHASE > 1) ? $clog2(PHASE) : 1;
    localparam int TW = $clog2(HS_TIMEOUT + 1);
    localparam int HW = $clog2(HS_MIN + 1);

    kbd_state_t                     state;
    logic [PW-1:0]                  phase_cnt;
    logic [1:0]                     sub;
    logic [2:0]                     bits_left;
    logic [7:0]                     shreg;
    logic [7:0]                     cur_byte;
    logic [TW-1:0]                  to_cnt;
    logic [HW-1:0]                  hs_cnt;
    logic                           kin_s1;
    logic                           kin_s2;
    logic [1:0]                     init_pend;
    logic                           lost_pend;
    logic                           resend_pend;
    logic                           rs_wait;

    logic                           kbd_req;
    logic                           fifo_pop;
    logic [7:0]                     fifo_dout;
    logic [$clog2(FIFO_DEPTH):0]    fifo_count;
    logic                           fifo_full;
    logic                           fifo_empty;

    logic                           phase_end;
    logic                           pulsing;
    logic                           hs_window;
    logic                           hs_hit;
    logic                           timeout;
    logic                           start_tx;
    logic [7:0]                     start_byte;

    assign kbd_req   = KBD_MOUSE_STROBE && (KBD_MOUSE_TYPE == KMT_KEYBOARD);
    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
    assign phase_end = (phase_cnt == PW'(PHASE - 1));
    assign pulsing   = (state == ST_SEND) || (state == ST_RESYNC && !rs_wait);
    assign hs_window = (state == ST_WAIT_HS) || (state == ST_RESYNC && rs_wait);
    assign hs_hit    = hs_window && !kin_s2 && (hs_cnt == HW'(HS_MIN - 1));
    assign timeout   = (to_cnt == TW'(HS_TIMEOUT - 1));
    assign start_tx  = (state == ST_INIT) || fifo_pop ||
                       (state == ST_WAIT_REL && kin_s2 && (lost_pend || resend_pend));

    kbd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .push    (kbd_req),
        .din     (KBD_MOUSE_DATA),
        .pop     (fifo_pop),
        .dout    (fifo_dout),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        start_byte = fifo_dout;
        case (state)
            ST_INIT:     start_byte = (init_pend == 2'd2) ? KC_INIT_PWR : KC_INIT_END;
            ST_WAIT_REL: start_byte = lost_pend ? KC_LOST_SYNC : cur_byte;
            default:     start_byte = fifo_dout;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            kin_s1 <= 1'b1;
            kin_s2 <= 1'b1;
        end else begin
            kin_s1 <= kdat_in;
            kin_s2 <= kin_s1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= ST_INIT;
            init_pend   <= 2'd2;
            lost_pend   <= 1'b0;
            resend_pend <= 1'b0;
            rs_wait     <= 1'b0;
            phase_cnt   <= '0;
            sub         <= 2'd0;
            bits_left   <= 3'd0;
            shreg       <= 8'h00;
            cur_byte    <= 8'h00;
            to_cnt      <= '0;
            hs_cnt      <= '0;
            kclk_out    <= 1'b1;
            kdat_out    <= 1'b1;
            busy        <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            busy <= (state != ST_IDLE) || (fifo_count != '0);
            if (kbd_req && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end

            if (!hs_window || kin_s2) begin
                hs_cnt <= '0;
            end else if (hs_cnt != HW'(HS_MIN - 1)) begin
                hs_cnt <= hs_cnt + HW'(1);
            end

            // The first data bit goes out on the same edge the byte is chosen.
            if (start_tx) begin
                shreg     <= kbd_encode(start_byte);
                kdat_out  <= ~start_byte[6];
                phase_cnt <= '0;
                sub       <= 2'd0;
                bits_left <= 3'd7;
                state     <= ST_SEND;
            end

            // Shared bit clock: data phase, KCLK low phase, KCLK high phase.
            if (pulsing) begin
                if (phase_end) begin
                    phase_cnt <= '0;
                    case (sub)
                        2'd0: begin
                            kclk_out <= 1'b0;
                            sub      <= 2'd1;
                        end
                        2'd1: begin
                            kclk_out <= 1'b1;
                            sub      <= 2'd2;
                        end
                        default: begin
                            sub <= 2'd0;
                            if (bits_left == 3'd0) begin
                                kdat_out <= 1'b1;
                                to_cnt   <= '0;
                                if (state == ST_SEND) begin
                                    state <= ST_WAIT_HS;
                                end else begin
                                    rs_wait <= 1'b1;
                                end
                            end else begin
                                kdat_out  <= ~shreg[6];
                                shreg     <= {shreg[6:0], 1'b0};
                                bits_left <= bits_left - 3'd1;
                            end
                        end
                    endcase
                end else begin
                    phase_cnt <= phase_cnt + PW'(1);
                end
            end

            case (state)
                ST_INIT: begin
                    init_pend <= init_pend - 2'd1;
                    cur_byte  <= start_byte;
                end
                ST_IDLE: begin
                    if (fifo_pop) begin
                        cur_byte <= fifo_dout;
                    end
                end
                ST_WAIT_HS: begin
                    if (hs_hit) begin
                        state <= ST_WAIT_REL;
                    end else if (timeout) begin
                        state     <= ST_RESYNC;
                        rs_wait   <= 1'b0;
                        kdat_out  <= 1'b0;
                        phase_cnt <= '0;
                        sub       <= 2'd0;
                        bits_left <= 3'd0;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                ST_WAIT_REL: begin
                    if (kin_s2) begin
                        if (lost_pend) begin
                            lost_pend   <= 1'b0;
                            resend_pend <= 1'b1;
                        end else if (resend_pend) begin
                            resend_pend <= 1'b0;
                        end else if (init_pend != 2'd0) begin
                            state <= ST_INIT;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_RESYNC: begin
                    if (rs_wait) begin
                        if (hs_hit) begin
                            state     <= ST_WAIT_REL;
                            lost_pend <= 1'b1;
                        end else if (timeout) begin
                            rs_wait   <= 1'b0;
                            kdat_out  <= 1'b0;
                            phase_cnt <= '0;
                            sub       <= 2'd0;
                            bits_left <= 3'd0;
                        end else begin
                            to_cnt <= to_cnt + TW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
